multiplexer_n_2to1_arbiter: RTL and testbench

Two-requester arbiter that shares one `multiplexer_N_2to1` datapath between two valid/ready sources and feeds a single registered valid/ready sink. It sits between two producer stages (e.g. two adder result streams) and one downstream consumer. It generates the mux `select` from a grant decision and holds the output stable under back-pressure. Arbitration is round-robin, or fixed-priority if the configuration macro is left undefined.

---
 rtl/multiplexer_n_2to1_arbiter_pkg.sv | 17 +
 rtl/multiplexer_n_2to1_arbiter_mux.sv | 21 ++
 rtl/multiplexer_n_2to1_arbiter.sv | 121 ++++++++++++
 tb/tb_multiplexer_n_2to1_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multiplexer_n_2to1_arbiter_pkg.sv
// Shared constants and helpers for the two-requester mux arbiter.
// Source indices, the reset value of the last-served tracker and the
// round-robin preference helper live here so the top and the bench agree.
package multiplexer_n_2to1_arbiter_pkg;

    localparam logic SRC_IN0      = 1'b0;
    localparam logic SRC_IN1      = 1'b1;

    // last_src resets to in1 so that in0 wins the first contention.
    localparam logic LAST_SRC_RST = SRC_IN1;

    // Under contention, round-robin favours the source not served last.
    function automatic logic other_src(input logic last_src);
        return (last_src == SRC_IN0) ? SRC_IN1 : SRC_IN0;
    endfunction

endpackage

// File: rtl/multiplexer_n_2to1_arbiter_mux.sv
// N+1 bit wide 2:1 multiplexer shared by both requesters.
// select = 0 passes in0, select = 1 passes in1.
module multiplexer_n_2to1 #(
    parameter int N = 2
) (
    input  logic [N:0] in0,
    input  logic [N:0] in1,
    input  logic       select,
    output logic [N:0] y
);

    // Pure datapath selection, no state.
    always_comb begin
        if (select) begin
            y = in1;
        end else begin
            y = in0;
        end
    end

endmodule

// File: rtl/multiplexer_n_2to1_arbiter.sv
// Two-requester valid/ready arbiter feeding one registered output stage
// through a shared multiplexer_n_2to1.
// Build option: define MUX_ARB_ROUND_ROBIN_EN for alternating grants under
// contention; left undefined, in0 always wins (fixed priority).
// The EMPTY/FULL state is carried by out_valid itself.
module multiplexer_n_2to1_arbiter
    import multiplexer_n_2to1_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in0_valid,
    input  logic [N:0] in0_data,
    output logic       in0_ready,
    input  logic       in1_valid,
    input  logic [N:0] in1_data,
    output logic       in1_ready,
    output logic       out_valid,
    output logic [N:0] out_data,
    output logic       out_src,
    input  logic       out_ready
);

    logic       load_s;
    logic       grant0_s;
    logic       grant1_s;
    logic       grant_any_s;
    logic       contention_winner_s;
    logic [N:0] mux_data_s;

    logic       out_valid_r;
    logic [N:0] out_data_r;
    logic       out_src_r;
    logic       last_src_r;

`ifdef MUX_ARB_ROUND_ROBIN_EN
    assign contention_winner_s = other_src(last_src_r);
`else
    // last_src is still tracked in fixed-priority builds so both builds share
    // the same register behaviour; only the contention decision ignores it.
    logic unused_last_src_s;
    assign unused_last_src_s   = last_src_r;
    assign contention_winner_s = SRC_IN0;
`endif

    // Output register may take a new beat when empty or being drained.
    always_comb begin
        load_s = !out_valid_r || out_ready;
    end

    // Grant decision from the valids only; data never reaches control.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case ({in1_valid, in0_valid})
            2'b01: begin
                grant0_s = 1'b1;
            end
            2'b10: begin
                grant1_s = 1'b1;
            end
            2'b11: begin
                if (contention_winner_s == SRC_IN1) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b1;
                end
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
        grant_any_s = grant0_s || grant1_s;
    end

    // Handshake completes only when the output stage can load and not in reset.
    always_comb begin
        in0_ready = load_s && grant0_s && !rst;
        in1_ready = load_s && grant1_s && !rst;
    end

    multiplexer_n_2to1 #(
        .N (N)
    ) u_mux (
        .in0    (in0_data),
        .in1    (in1_data),
        .select (grant1_s),
        .y      (mux_data_s)
    );

    // Output stage: capture on grant, drain to empty without one, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {(N+1){1'b0}};
            out_src_r   <= SRC_IN0;
            last_src_r  <= LAST_SRC_RST;
        end else if (load_s) begin
            if (grant_any_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= mux_data_s;
                out_src_r   <= grant1_s ? SRC_IN1 : SRC_IN0;
                last_src_r  <= grant1_s ? SRC_IN1 : SRC_IN0;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_src_r   <= out_src_r;
            last_src_r  <= last_src_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_multiplexer_n_2to1_arbiter.sv
// Self-checking bench for multiplexer_n_2to1_arbiter (N=7).
// Directed table of corner cases followed by random traffic checked against
// a transaction-level model and a beat scoreboard.
module tb_multiplexer_n_2to1_arbiter;

    localparam int N = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_valid;
    logic [N:0] in0_data;
    logic       in0_ready;
    logic       in1_valid;
    logic [N:0] in1_data;
    logic       in1_ready;
    logic       out_valid;
    logic [N:0] out_data;
    logic       out_src;
    logic       out_ready;

    int tests = 0;
    int fails = 0;

    multiplexer_n_2to1_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic       r0;
        logic       r1;
        logic       ov;
        logic [7:0] od;
        logic       os;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       s;
    } beat_t;

    vec_t  vecs [16];
    beat_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner by the arbitration rules: -1 none, 0 in0, 1 in1.
    function automatic int pick(input bit v0, input bit v1, input int last);
        if (v0 && v1) begin
`ifdef MUX_ARB_ROUND_ROBIN_EN
            return 1 - last;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Model state: contents of the output slot and last served source.
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_src;
    int       m_last;

    initial begin
        bit       p0, p1, load_m, acc0, acc1;
        bit [7:0] d0, d1;
        int       w;
        beat_t    b;

        // rst v0 d0 v1 d1 ordy | r0 r1 ov od os
        vecs[0]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
`ifdef MUX_ARB_ROUND_ROBIN_EN
        vecs[3]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
`else
        vecs[3]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
`endif
        // fill with A5, then stall three cycles with in1 waiting, then release
        vecs[7]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1};
        // pop with nobody requesting: empties, data holds
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1};
        // fill, reset while full and contended, then first contention goes to in0
        vecs[13] = '{1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};

        for (int i = 0; i < 16; i++) begin
            rst       = vecs[i].rst;
            in0_valid = vecs[i].v0;
            in0_data  = vecs[i].d0;
            in1_valid = vecs[i].v1;
            in1_data  = vecs[i].d1;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in0_ready", i), {31'd0, in0_ready}, {31'd0, vecs[i].r0});
            chk($sformatf("v%0d_in1_ready", i), {31'd0, in1_ready}, {31'd0, vecs[i].r1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
            chk($sformatf("v%0d_out_data", i), {24'd0, out_data}, {24'd0, vecs[i].od});
            chk($sformatf("v%0d_out_src", i), {31'd0, out_src}, {31'd0, vecs[i].os});
        end

        // Random phase: start from a clean reset.
        rst       = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_src   = 1'b0;
        m_last  = 1;
        p0 = 1'b0;
        p1 = 1'b0;
        d0 = 8'h00;
        d1 = 8'h00;

        for (int c = 0; c < 10000; c++) begin
            if (!p0 && $urandom_range(0, 99) < 60) begin
                p0 = 1'b1;
                d0 = 8'($urandom);
            end
            if (!p1 && $urandom_range(0, 99) < 60) begin
                p1 = 1'b1;
                d1 = 8'($urandom);
            end
            in0_valid = p0;
            in0_data  = d0;
            in1_valid = p1;
            in1_data  = d1;
            out_ready = ($urandom_range(0, 99) < 70);
            #1;

            load_m = !m_valid || out_ready;
            w      = pick(p0, p1, m_last);
            acc0   = load_m && (w == 0);
            acc1   = load_m && (w == 1);
            chk("rnd_in0_ready", {31'd0, in0_ready}, {31'd0, acc0});
            chk("rnd_in1_ready", {31'd0, in1_ready}, {31'd0, acc1});
            chk("rnd_ready_onehot", {31'd0, in0_ready & in1_ready}, 32'd0);
            chk("rnd_ready_stall",
                {31'd0, (in0_ready | in1_ready) & out_valid & ~out_ready}, 32'd0);

            // Sink handshake consumes the oldest captured beat.
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_pop_unexpected", 32'd1, 32'd0);
                end else begin
                    b = sb.pop_front();
                    chk("rnd_pop_data", {24'd0, out_data}, {24'd0, b.d});
                    chk("rnd_pop_src", {31'd0, out_src}, {31'd0, b.s});
                end
            end

            if (load_m) begin
                if (w >= 0) begin
                    m_valid = 1'b1;
                    m_data  = (w == 1) ? d1 : d0;
                    m_src   = (w == 1);
                    m_last  = w;
                    b.d     = m_data;
                    b.s     = m_src;
                    sb.push_back(b);
                    if (w == 0) p0 = 1'b0;
                    else        p1 = 1'b0;
                end else begin
                    m_valid = 1'b0;
                end
            end

            @(posedge clk);
            #1;
            chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("rnd_out_data", {24'd0, out_data}, {24'd0, m_data});
            chk("rnd_out_src", {31'd0, out_src}, {31'd0, m_src});
        end

        chk("end_sb_occupancy", sb.size(), {31'd0, m_valid});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
